// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter sharing one 8-bit signed add/sub unit.
// Optional saturating overflow counter: define ADDSUB_ARB_OVFL_CNT_EN.

module addsub8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    output logic [7:0] s,
    output logic       ovfl
);
    logic [7:0] b_eff;

    always_comb begin
        b_eff = sub ? ~b : b;
        s     = a + b_eff + {7'd0, sub};
        // signed overflow: like-signed operands producing a result of the other sign
        ovfl  = (a[7] == b_eff[7]) && (s[7] != a[7]);
    end
endmodule

module addsub_arbiter #(
    parameter int FIXED_PRI = 0
`ifdef ADDSUB_ARB_OVFL_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req0_sub,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic       req1_sub,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_s,
    output logic       rsp_ovfl,
    output logic       rsp_id,
    output logic       busy
`ifdef ADDSUB_ARB_OVFL_CNT_EN
    ,
    output logic [CNT_W-1:0] ovfl_cnt
`endif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       ptr;
    logic       grant_any;
    logic       grant_id;
    logic [7:0] cap_a;
    logic [7:0] cap_b;
    logic       cap_sub;
    logic       cap_id;
    logic [7:0] alu_s;
    logic       alu_ovfl;
    logic       rsp_fire;

    addsub8 u_addsub8 (
        .a    (cap_a),
        .b    (cap_b),
        .sub  (cap_sub),
        .s    (alu_s),
        .ovfl (alu_ovfl)
    );

    assign rsp_fire = (state == RESP) && rsp_ready;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        grant_any  = 1'b0;
        grant_id   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    grant_any = 1'b1;
                    grant_id  = (FIXED_PRI != 0) ? 1'b0 : ptr;
                end else if (req0_valid) begin
                    grant_any = 1'b1;
                    grant_id  = 1'b0;
                end else if (req1_valid) begin
                    grant_any = 1'b1;
                    grant_id  = 1'b1;
                end
                if (grant_any) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_nxt  = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_sub   <= 1'b0;
            cap_id    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_s     <= '0;
            rsp_ovfl  <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && grant_any) begin
                cap_a   <= grant_id ? req1_a : req0_a;
                cap_b   <= grant_id ? req1_b : req0_b;
                cap_sub <= grant_id ? req1_sub : req0_sub;
                cap_id  <= grant_id;
                if (FIXED_PRI == 0) ptr <= ~grant_id;
            end
            if (state == EXEC) begin
                rsp_s     <= alu_s;
                rsp_ovfl  <= alu_ovfl;
                rsp_id    <= cap_id;
                rsp_valid <= 1'b1;
            end
            if (rsp_fire) rsp_valid <= 1'b0;
        end
    end

`ifdef ADDSUB_ARB_OVFL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovfl_cnt <= '0;
        end else if (rsp_fire && rsp_ovfl && (ovfl_cnt != '1)) begin
            ovfl_cnt <= ovfl_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter (round-robin and fixed-priority instances).
// Checks ovfl_cnt as well when ADDSUB_ARB_OVFL_CNT_EN is defined.

module tb_addsub_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_sub;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_sub;
    logic [7:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_ovfl, rsp_id, busy;
    logic [7:0] rsp_s;
    logic       fix_req0_ready, fix_req1_ready, fix_rsp_valid, fix_rsp_ovfl, fix_rsp_id, fix_busy;
    logic [7:0] fix_rsp_s;
`ifdef ADDSUB_ARB_OVFL_CNT_EN
    logic [7:0] ovfl_cnt, fix_ovfl_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    addsub_arbiter #(.FIXED_PRI(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_s(rsp_s), .rsp_ovfl(rsp_ovfl), .rsp_id(rsp_id),
        .busy(busy)
`ifdef ADDSUB_ARB_OVFL_CNT_EN
        , .ovfl_cnt(ovfl_cnt)
`endif
    );

    addsub_arbiter #(.FIXED_PRI(1)) u_fix (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(fix_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(fix_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp_valid(fix_rsp_valid), .rsp_ready(1'b1), .rsp_s(fix_rsp_s), .rsp_ovfl(fix_rsp_ovfl), .rsp_id(fix_rsp_id),
        .busy(fix_busy)
`ifdef ADDSUB_ARB_OVFL_CNT_EN
        , .ovfl_cnt(fix_ovfl_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int port, input string tag);
        int k;
        k = 0;
        #1;
        while (!((port == 0) ? req0_ready : req1_ready) && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(tag, {15'd0, (port == 0) ? req0_ready : req1_ready}, 16'd1);
    endtask

    task automatic wait_rsp(input string tag);
        int k;
        k = 0;
        #1;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(tag, {15'd0, rsp_valid}, 16'd1);
    endtask

    // Issue one op on a port, consume its response (rsp_ready assumed high), return to IDLE.
    task automatic single_op(input int port, input logic [7:0] a, input logic [7:0] b, input logic sub,
                             input logic [7:0] es, input logic eo, input string tag);
        if (port == 0) begin
            req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
        end
        wait_ready(port, {tag, "_rdy"});
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp({tag, "_vld"});
        chk({tag, "_s"}, {8'd0, rsp_s}, {8'd0, es});
        chk({tag, "_ovfl"}, {15'd0, rsp_ovfl}, {15'd0, eo});
        chk({tag, "_id"}, {15'd0, rsp_id}, (port == 0) ? 16'd0 : 16'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk({tag, "_done"}, {15'd0, rsp_valid}, 16'd0);
    endtask

    initial begin
        logic [5:0] g_main, g_fix;
        int nm, nf, both_hi;
        rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_a = '0; req1_b = '0; req1_sub = 1'b0;

        // reset values
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {15'd0, rsp_valid}, 16'd0);
        chk("rst_s", {8'd0, rsp_s}, 16'd0);
        chk("rst_ovfl", {15'd0, rsp_ovfl}, 16'd0);
        chk("rst_id", {15'd0, rsp_id}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_fix_busy", {15'd0, fix_busy}, 16'd0);
`ifdef ADDSUB_ARB_OVFL_CNT_EN
        chk("rst_cnt", {8'd0, ovfl_cnt}, 16'd0);
`endif
        rst = 1'b0;

        // single req0 with explicit latency
        req0_a = 8'h05; req0_b = 8'h03; req0_sub = 1'b0; req0_valid = 1'b1;
        #1;
        chk("lat_rdy0", {15'd0, req0_ready}, 16'd1);
        chk("lat_rdy1", {15'd0, req1_ready}, 16'd0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("lat_exec_busy", {15'd0, busy}, 16'd1);
        chk("lat_exec_rdy", {15'd0, req0_ready}, 16'd0);
        chk("lat_exec_vld", {15'd0, rsp_valid}, 16'd0);
        @(negedge clk);
        chk("lat_resp_vld", {15'd0, rsp_valid}, 16'd1);
        chk("lat_s", {8'd0, rsp_s}, 16'h08);
        chk("lat_ovfl", {15'd0, rsp_ovfl}, 16'd0);
        chk("lat_id", {15'd0, rsp_id}, 16'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("lat_idle_vld", {15'd0, rsp_valid}, 16'd0);
        chk("lat_idle_busy", {15'd0, busy}, 16'd0);
        chk("lat_keep_s", {8'd0, rsp_s}, 16'h08);

        // both valid from reset: req0 first, then req1
        do_reset();
        rsp_ready = 1'b1;
        req0_a = 8'h7F; req0_b = 8'h01; req0_sub = 1'b0; req0_valid = 1'b1;
        req1_a = 8'h10; req1_b = 8'h20; req1_sub = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rr_rdy0", {15'd0, req0_ready}, 16'd1);
        chk("rr_rdy1", {15'd0, req1_ready}, 16'd0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        wait_rsp("rr_vld_a");
        chk("rr_s_a", {8'd0, rsp_s}, 16'h80);
        chk("rr_ovfl_a", {15'd0, rsp_ovfl}, 16'd1);
        chk("rr_id_a", {15'd0, rsp_id}, 16'd0);
        @(negedge clk);
        wait_ready(1, "rr_rdy_b");
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp("rr_vld_b");
        chk("rr_s_b", {8'd0, rsp_s}, 16'hF0);
        chk("rr_ovfl_b", {15'd0, rsp_ovfl}, 16'd0);
        chk("rr_id_b", {15'd0, rsp_id}, 16'd1);
        @(posedge clk);
        @(negedge clk);

        // both held valid for six grants: round-robin alternates, fixed priority stays on req0
        do_reset();
        rsp_ready = 1'b1;
        req0_a = 8'h01; req0_b = 8'h02; req0_sub = 1'b0; req0_valid = 1'b1;
        req1_a = 8'h03; req1_b = 8'h04; req1_sub = 1'b0; req1_valid = 1'b1;
        g_main = '0; g_fix = '0; nm = 0; nf = 0; both_hi = 0;
        #1;
        for (int c = 0; c < 40 && (nm < 6 || nf < 6); c++) begin
            if (req0_ready && req1_ready) both_hi++;
            if (nm < 6 && (req0_ready || req1_ready)) begin
                g_main[nm] = req1_ready;
                nm++;
            end
            if (nf < 6 && (fix_req0_ready || fix_req1_ready)) begin
                g_fix[nf] = fix_req1_ready;
                nf++;
            end
            @(negedge clk);
            #1;
        end
        chk("alt_count", nm[15:0], 16'd6);
        chk("alt_order", {10'd0, g_main}, 16'b101010);
        chk("fix_count", nf[15:0], 16'd6);
        chk("fix_order", {10'd0, g_fix}, 16'd0);
        chk("never_both", both_hi[15:0], 16'd0);
        do_reset();

        // overflow boundary table
        rsp_ready = 1'b1;
        single_op(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b1, "ov_7f_p_01");
        single_op(0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, "ov_80_m_01");
        single_op(1, 8'h00, 8'h80, 1'b1, 8'h80, 1'b1, "ov_00_m_80");
        single_op(0, 8'h80, 8'h80, 1'b1, 8'h00, 1'b0, "ov_80_m_80");
        single_op(1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, "ov_ff_p_01");
        single_op(0, 8'hC0, 8'hC0, 1'b0, 8'h80, 1'b0, "ov_c0_p_c0");
        single_op(1, 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, "ov_80_p_ff");

        // consumer stall with a competing request pending
        rsp_ready = 1'b0;
        req0_a = 8'h22; req0_b = 8'h11; req0_sub = 1'b0; req0_valid = 1'b1;
        wait_ready(0, "stall_rdy");
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_a = 8'h01; req1_b = 8'h01; req1_sub = 1'b0; req1_valid = 1'b1;
        wait_rsp("stall_vld");
        for (int c = 0; c < 10; c++) begin
            chk("stall_s", {8'd0, rsp_s}, 16'h33);
            chk("stall_valid", {15'd0, rsp_valid}, 16'd1);
            chk("stall_rdy0", {15'd0, req0_ready}, 16'd0);
            chk("stall_rdy1", {15'd0, req1_ready}, 16'd0);
            chk("stall_busy", {15'd0, busy}, 16'd1);
            @(negedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("stall_rel_busy", {15'd0, busy}, 16'd0);
        chk("stall_rel_vld", {15'd0, rsp_valid}, 16'd0);
        chk("stall_rel_rdy1", {15'd0, req1_ready}, 16'd1);
        chk("stall_keep_s", {8'd0, rsp_s}, 16'h33);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp("stall_next_vld");
        chk("stall_next_s", {8'd0, rsp_s}, 16'h02);
        chk("stall_next_id", {15'd0, rsp_id}, 16'd1);
        @(posedge clk);
        @(negedge clk);

        // reset while in EXEC
        req0_a = 8'h7F; req0_b = 8'h7F; req0_sub = 1'b0; req0_valid = 1'b1;
        wait_ready(0, "rexec_rdy");
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("rexec_busy", {15'd0, busy}, 16'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rexec_vld", {15'd0, rsp_valid}, 16'd0);
        chk("rexec_s", {8'd0, rsp_s}, 16'd0);
        chk("rexec_ovfl", {15'd0, rsp_ovfl}, 16'd0);
        chk("rexec_id", {15'd0, rsp_id}, 16'd0);
        chk("rexec_busy0", {15'd0, busy}, 16'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("rexec_no_rsp", {15'd0, rsp_valid}, 16'd0);
        end

        // reset while in RESP
        rsp_ready = 1'b0;
        req1_a = 8'h80; req1_b = 8'h01; req1_sub = 1'b1; req1_valid = 1'b1;
        wait_ready(1, "rresp_rdy");
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp("rresp_vld");
        chk("rresp_s_pre", {8'd0, rsp_s}, 16'h7F);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rresp_vld0", {15'd0, rsp_valid}, 16'd0);
        chk("rresp_s", {8'd0, rsp_s}, 16'd0);
        chk("rresp_ovfl", {15'd0, rsp_ovfl}, 16'd0);
        chk("rresp_id", {15'd0, rsp_id}, 16'd0);
        chk("rresp_busy", {15'd0, busy}, 16'd0);

`ifdef ADDSUB_ARB_OVFL_CNT_EN
        do_reset();
        rsp_ready = 1'b1;
        single_op(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b1, "cnt_a");
        single_op(1, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, "cnt_n");
        single_op(1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, "cnt_b");
        single_op(0, 8'h00, 8'h80, 1'b1, 8'h80, 1'b1, "cnt_c");
        chk("cnt_three", {8'd0, ovfl_cnt}, 16'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("cnt_rst", {8'd0, ovfl_cnt}, 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end
endmodule
